// File: rtl/urv_ifetch.sv
// Instruction fetch stage: sequential PC generation, single-outstanding memory reads,
// one-entry skid buffer for stalls, and redirect with stale-response discard.
// Optional misaligned-redirect flag: define URV_IFETCH_MISALIGN_CHECK_EN.
module urv_ifetch #(
   parameter logic [31:0] g_reset_vector = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] im_addr_o,
   output logic        im_rd_o,
   input  logic [31:0] im_data_i,
   input  logic        im_valid_i,
   input  logic        f_stall_i,
   input  logic        x_bra_i,
   input  logic [31:0] x_bra_target_i,
   output logic [31:0] f_ir_o,
   output logic [31:0] f_pc_o,
   output logic        f_valid_o
`ifdef URV_IFETCH_MISALIGN_CHECK_EN
   ,
   output logic        f_misaligned_o
`endif
);

   logic [31:0] pc;
   logic [31:0] req_pc;
   logic [31:0] skid_ir;
   logic [31:0] skid_pc;
   logic        outstanding;
   logic        skid_valid;
   logic        discard;
   logic        issue;
   logic        rsp;
   logic        take_rsp;
   logic [31:0] bra_pc;

   assign bra_pc   = {x_bra_target_i[31:2], 2'b00};
   assign rsp      = im_valid_i && outstanding;
   assign take_rsp = rsp && !discard;
   // A response arriving this cycle frees the single slot, so issue can overlap it.
   assign issue    = !rst_i && !x_bra_i && !f_stall_i && !skid_valid &&
                     (!outstanding || im_valid_i);

   assign im_rd_o   = issue;
   assign im_addr_o = pc;

   // Request / response / output stage
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc          <= g_reset_vector;
         outstanding <= 1'b0;
         skid_valid  <= 1'b0;
         discard     <= 1'b0;
         f_ir_o      <= 32'h0;
         f_pc_o      <= 32'h0;
         f_valid_o   <= 1'b0;
      end else if (x_bra_i) begin
         pc          <= bra_pc;
         outstanding <= outstanding && !im_valid_i;
         discard     <= outstanding && !im_valid_i;
         skid_valid  <= 1'b0;
         f_valid_o   <= 1'b0;
      end else begin
         if (issue) begin
            pc          <= pc + 32'd4;
            outstanding <= 1'b1;
         end else if (rsp) begin
            outstanding <= 1'b0;
         end

         if (rsp && discard)
            discard <= 1'b0;

         if (!f_stall_i) begin
            if (skid_valid) begin
               f_ir_o     <= skid_ir;
               f_pc_o     <= skid_pc;
               f_valid_o  <= 1'b1;
               skid_valid <= 1'b0;
            end else if (take_rsp) begin
               f_ir_o    <= im_data_i;
               f_pc_o    <= req_pc;
               f_valid_o <= 1'b1;
            end else begin
               f_valid_o <= 1'b0;
            end
         end else if (take_rsp) begin
            skid_valid <= 1'b1;
         end
      end
   end

   // Datapath registers qualified by the control above; no reset needed
   always_ff @(posedge clk_i) begin
      if (issue)
         req_pc <= pc;
      if (take_rsp && f_stall_i && !x_bra_i) begin
         skid_ir <= im_data_i;
         skid_pc <= req_pc;
      end
   end

`ifdef URV_IFETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         f_misaligned_o <= 1'b0;
      else
         f_misaligned_o <= x_bra_i && (x_bra_target_i[1:0] != 2'b00);
   end
`else
   logic unused_tgt_lsb;
   assign unused_tgt_lsb = ^x_bra_target_i[1:0];
`endif

endmodule

// File: tb/tb_urv_ifetch.sv
// Directed bench for urv_ifetch: reset, sequential fetch, stall/skid, redirects,
// PC wrap, misaligned redirect and reset mid-operation.
module tb_urv_ifetch;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic [31:0] im_addr;
   logic        im_rd;
   logic [31:0] im_data;
   logic        im_valid;
   logic        stall;
   logic        bra;
   logic [31:0] tgt;
   logic [31:0] f_ir;
   logic [31:0] f_pc;
   logic        f_valid;
`ifdef URV_IFETCH_MISALIGN_CHECK_EN
   logic        f_mis;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int lat   = 1;
   int mem_cnt = 0;
   logic [31:0] mem_addr = 32'h0;

   urv_ifetch #(.g_reset_vector(32'h0000_0100)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .im_addr_o      (im_addr),
      .im_rd_o        (im_rd),
      .im_data_i      (im_data),
      .im_valid_i     (im_valid),
      .f_stall_i      (stall),
      .x_bra_i        (bra),
      .x_bra_target_i (tgt),
      .f_ir_o         (f_ir),
      .f_pc_o         (f_pc),
      .f_valid_o      (f_valid)
`ifdef URV_IFETCH_MISALIGN_CHECK_EN
      ,
      .f_misaligned_o (f_mis)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: fixed latency per request, data = address ^ K
   initial begin
      im_valid = 1'b0;
      im_data  = 32'h0;
   end
   always @(posedge clk) begin
      im_valid <= 1'b0;
      if (mem_cnt > 1)
         mem_cnt <= mem_cnt - 1;
      else if (mem_cnt == 1) begin
         im_valid <= 1'b1;
         im_data  <= mem_addr ^ K;
         mem_cnt  <= 0;
      end
      if (im_rd) begin
         if (lat == 1) begin
            im_valid <= 1'b1;
            im_data  <= im_addr ^ K;
         end else begin
            mem_cnt  <= lat - 1;
            mem_addr <= im_addr;
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (2) step();
      n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", f_valid); end
      n_cmp++; if (f_ir !== 32'h0) begin n_err++; $display("FAIL rst_ir: got %h expected 0", f_ir); end
      n_cmp++; if (f_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h expected 0", f_pc); end
      n_cmp++; if (im_rd !== 1'b0) begin n_err++; $display("FAIL rst_rd: got %b expected 0", im_rd); end
      rst = 1'b0;
      #1;
      n_cmp++; if (im_rd !== 1'b1) begin n_err++; $display("FAIL first_rd: got %b expected 1", im_rd); end
      n_cmp++; if (im_addr !== 32'h100) begin n_err++; $display("FAIL first_addr: got %h expected 00000100", im_addr); end
   endtask

   task automatic test_sequential;
      logic [31:0] epc;
      step();
      n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL seq_c1_valid: got %b expected 0", f_valid); end
      n_cmp++; if (im_addr !== 32'h104) begin n_err++; $display("FAIL seq_c1_addr: got %h expected 00000104", im_addr); end
      for (int k = 0; k < 4; k++) begin
         step();
         epc = 32'h100 + 32'(4 * k);
         n_cmp++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid: got %b expected 1", f_valid); end
         n_cmp++; if (f_pc !== epc) begin n_err++; $display("FAIL seq_pc: got %h expected %h", f_pc, epc); end
         n_cmp++; if (f_ir !== (epc ^ K)) begin n_err++; $display("FAIL seq_ir: got %h expected %h", f_ir, epc ^ K); end
         n_cmp++; if (im_addr !== epc + 32'h8) begin n_err++; $display("FAIL seq_addr: got %h expected %h", im_addr, epc + 32'h8); end
         n_cmp++; if (im_rd !== 1'b1) begin n_err++; $display("FAIL seq_rd: got %b expected 1", im_rd); end
      end
   endtask

   task automatic test_stall;
      step();
      n_cmp++; if (f_pc !== 32'h110) begin n_err++; $display("FAIL stall_pre_pc: got %h expected 00000110", f_pc); end
      stall = 1'b1;
      #1;
      n_cmp++; if (im_rd !== 1'b0) begin n_err++; $display("FAIL stall_rd: got %b expected 0", im_rd); end
      repeat (2) begin
         step();
         n_cmp++; if (f_pc !== 32'h110 || f_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold: got pc %h v %b expected 00000110 1", f_pc, f_valid); end
         n_cmp++; if (im_rd !== 1'b0) begin n_err++; $display("FAIL stall_hold_rd: got %b expected 0", im_rd); end
      end
      step();
      stall = 1'b0;
      #1;
      n_cmp++; if (im_rd !== 1'b0) begin n_err++; $display("FAIL skid_block_rd: got %b expected 0", im_rd); end
      step();
      n_cmp++; if (f_pc !== 32'h114 || f_ir !== (32'h114 ^ K)) begin n_err++; $display("FAIL skid_out: got %h/%h expected 00000114/%h", f_pc, f_ir, 32'h114 ^ K); end
      n_cmp++; if (im_rd !== 1'b1 || im_addr !== 32'h118) begin n_err++; $display("FAIL resume_addr: got %b %h expected 1 00000118", im_rd, im_addr); end
      step();
      n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL resume_bubble: got %b expected 0", f_valid); end
      step();
      n_cmp++; if (f_pc !== 32'h118 || f_valid !== 1'b1) begin n_err++; $display("FAIL resume_118: got %h %b expected 00000118 1", f_pc, f_valid); end
      step();
      n_cmp++; if (f_pc !== 32'h11C || f_valid !== 1'b1) begin n_err++; $display("FAIL resume_11c: got %h %b expected 0000011c 1", f_pc, f_valid); end
   endtask

   task automatic test_redirect;
      int n;
      int stale;
      logic got;
      step();
      lat = 3; bra = 1'b1; tgt = 32'h100;
      step();
      bra = 1'b0;
      #1;
      n = 0;
      while (!(im_rd === 1'b1 && im_addr === 32'h10C) && n < 60) begin
         step();
         n++;
      end
      n_cmp++; if (n >= 60) begin n_err++; $display("FAIL bra_wait_10c: got timeout expected request 0000010c"); end
      step();
      bra = 1'b1; tgt = 32'h2000;
      #1;
      n_cmp++; if (im_rd !== 1'b0) begin n_err++; $display("FAIL bra_rd: got %b expected 0", im_rd); end
      step();
      bra = 1'b0;
      #1;
      n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL bra_valid: got %b expected 0", f_valid); end
      n_cmp++; if (im_rd !== 1'b0) begin n_err++; $display("FAIL bra_wait_rd: got %b expected 0", im_rd); end
      stale = 0;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         if (f_valid === 1'b1) begin
            if (f_pc === 32'h10C || f_ir === (32'h10C ^ K)) stale++;
            else begin
               got = 1'b1;
               n_cmp++; if (f_pc !== 32'h2000 || f_ir !== (32'h2000 ^ K)) begin n_err++; $display("FAIL bra_first: got %h/%h expected 00002000/%h", f_pc, f_ir, 32'h2000 ^ K); end
            end
         end
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL bra_timeout: got none expected 00002000"); end
      n_cmp++; if (stale != 0) begin n_err++; $display("FAIL bra_stale: got %0d expected 0", stale); end
   endtask

   task automatic test_redirect_stall;
      int n;
      lat = 1;
      repeat (8) step();
      n = 0;
      while (im_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      n_cmp++; if (n >= 20) begin n_err++; $display("FAIL bs_wait: got timeout expected response"); end
      stall = 1'b1;
      step();
      bra = 1'b1; tgt = 32'h3000;
      step();
      bra = 1'b0;
      #1;
      n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL bs_valid: got %b expected 0", f_valid); end
      n_cmp++; if (im_rd !== 1'b0) begin n_err++; $display("FAIL bs_rd: got %b expected 0", im_rd); end
      step();
      stall = 1'b0;
      #1;
      n_cmp++; if (im_rd !== 1'b1 || im_addr !== 32'h3000) begin n_err++; $display("FAIL bs_addr: got %b %h expected 1 00003000", im_rd, im_addr); end
      step();
      n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL bs_skid_cleared: got %b pc %h expected 0", f_valid, f_pc); end
      step();
      n_cmp++; if (f_valid !== 1'b1 || f_pc !== 32'h3000 || f_ir !== (32'h3000 ^ K)) begin n_err++; $display("FAIL bs_first: got %b %h/%h expected 1 00003000", f_valid, f_pc, f_ir); end
   endtask

   task automatic test_wrap;
      step();
      bra = 1'b1; tgt = 32'hFFFF_FFFC;
      step();
      bra = 1'b0;
      #1;
      n_cmp++; if (im_rd !== 1'b1 || im_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top: got %b %h expected 1 fffffffc", im_rd, im_addr); end
`ifdef URV_IFETCH_MISALIGN_CHECK_EN
      n_cmp++; if (f_mis !== 1'b0) begin n_err++; $display("FAIL wrap_mis: got %b expected 0", f_mis); end
`endif
      step();
      n_cmp++; if (im_rd !== 1'b1 || im_addr !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %b %h expected 1 00000000", im_rd, im_addr); end
      step();
      n_cmp++; if (f_pc !== 32'hFFFF_FFFC || f_valid !== 1'b1) begin n_err++; $display("FAIL wrap_out_top: got %h %b expected fffffffc 1", f_pc, f_valid); end
      step();
      n_cmp++; if (f_pc !== 32'h0 || f_ir !== K) begin n_err++; $display("FAIL wrap_out_zero: got %h/%h expected 00000000/%h", f_pc, f_ir, K); end
   endtask

   task automatic test_misalign;
      step();
      bra = 1'b1; tgt = 32'h0000_0203;
      step();
      bra = 1'b0;
      #1;
      n_cmp++; if (im_rd !== 1'b1 || im_addr !== 32'h200) begin n_err++; $display("FAIL mis_addr: got %b %h expected 1 00000200", im_rd, im_addr); end
`ifdef URV_IFETCH_MISALIGN_CHECK_EN
      n_cmp++; if (f_mis !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b expected 1", f_mis); end
`endif
      step();
`ifdef URV_IFETCH_MISALIGN_CHECK_EN
      n_cmp++; if (f_mis !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b expected 0", f_mis); end
`endif
      step();
      n_cmp++; if (f_pc !== 32'h200 || f_ir !== (32'h200 ^ K)) begin n_err++; $display("FAIL mis_out: got %h/%h expected 00000200/%h", f_pc, f_ir, 32'h200 ^ K); end
   endtask

   task automatic test_reset_midop;
      step();
      lat = 3;
      step();
      rst = 1'b1;
      #1;
      n_cmp++; if (f_valid !== 1'b0 || f_pc !== 32'h0 || f_ir !== 32'h0) begin n_err++; $display("FAIL mid_rst_out: got %b %h %h expected 0 0 0", f_valid, f_pc, f_ir); end
      n_cmp++; if (im_rd !== 1'b0 || im_addr !== 32'h100) begin n_err++; $display("FAIL mid_rst_req: got %b %h expected 0 00000100", im_rd, im_addr); end
      repeat (4) step();
      lat = 1;
      rst = 1'b0;
      #1;
      n_cmp++; if (im_rd !== 1'b1 || im_addr !== 32'h100) begin n_err++; $display("FAIL mid_restart: got %b %h expected 1 00000100", im_rd, im_addr); end
      step();
      n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale: got %b pc %h expected 0", f_valid, f_pc); end
      step();
      n_cmp++; if (f_valid !== 1'b1 || f_pc !== 32'h100 || f_ir !== (32'h100 ^ K)) begin n_err++; $display("FAIL mid_first: got %b %h/%h expected 1 00000100", f_valid, f_pc, f_ir); end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; bra = 1'b0; tgt = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_wrap();
      test_misalign();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
